// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin sharing of one combinational ALU between two
// requesters (0 = integer execute, 1 = address/branch-compare helper).
// Each requester owns a one-entry response buffer with valid/ready handshake.
module alu_share_arb #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [2*OP_W-1:0] req_op_i,
  input  logic [2*XLEN-1:0] req_a_i,
  input  logic [2*XLEN-1:0] req_b_i,
  output logic [1:0]        rsp_valid_o,
  input  logic [1:0]        rsp_ready_i,
  output logic [2*XLEN-1:0] rsp_data_o,
  output logic [1:0]        rsp_err_o,
  output logic [OP_W-1:0]   alu_ctrl_o,
  output logic [XLEN-1:0]   alu_a_o,
  output logic [XLEN-1:0]   alu_b_o,
  input  logic [XLEN-1:0]   alu_result_i
);

  localparam logic [OP_W-1:0] OP_ADD  = '0;
  // Highest defined ALU code (SLT); anything above is illegal.
  localparam logic [OP_W-1:0] OP_LAST = OP_W'(9);

  logic [1:0]        rsp_full_q, rsp_full_d;
  logic [2*XLEN-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic              last_grant_q, last_grant_d;

  logic [1:0]        elig;
  logic [1:0]        grant;
  logic [OP_W-1:0]   sel_op;
  logic [XLEN-1:0]   sel_a;
  logic [XLEN-1:0]   sel_b;
  logic              sel_illegal;

  // Eligibility and round-robin grant; a buffer being drained this cycle may
  // be refilled in the same cycle. Requests seen during reset are never granted.
  always_comb begin
    elig = req_valid_i & (~rsp_full_q | rsp_ready_i);
    if (rst_i) begin
      elig = 2'b00;
    end
    case (elig)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Operand/code mux onto the shared ALU; illegal codes run as ADD and are flagged.
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    if (grant[0]) begin
      sel_op = req_op_i[0 +: OP_W];
      sel_a  = req_a_i[0 +: XLEN];
      sel_b  = req_b_i[0 +: XLEN];
    end else if (grant[1]) begin
      sel_op = req_op_i[OP_W +: OP_W];
      sel_a  = req_a_i[XLEN +: XLEN];
      sel_b  = req_b_i[XLEN +: XLEN];
    end
    sel_illegal = (grant != 2'b00) && (sel_op > OP_LAST);
    alu_ctrl_o  = sel_illegal ? OP_ADD : sel_op;
    alu_a_o     = sel_a;
    alu_b_o     = sel_b;
  end

  // Response buffer next state: drain on ready, refill on grant (refill wins).
  always_comb begin
    rsp_full_d   = rsp_full_q & ~rsp_ready_i;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;
    for (int k = 0; k < 2; k++) begin
      if (grant[k]) begin
        rsp_full_d[k]                 = 1'b1;
        rsp_data_d[k*XLEN +: XLEN]    = alu_result_i;
        rsp_err_d[k]                  = sel_illegal;
        last_grant_d                  = 1'(k);
      end
    end
  end

  // State registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_full_q   <= 2'b00;
      rsp_data_q   <= '0;
      rsp_err_q    <= 2'b00;
      last_grant_q <= 1'b1;
    end else begin
      rsp_full_q   <= rsp_full_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req_ready_o = grant;
  assign rsp_valid_o = rsp_full_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed testbench for alu_share_arb with a behavioural shared ALU and a
// per-requester scoreboard of expected response-buffer contents.
module tb_alu_share_arb;

  localparam int XLEN = 32;
  localparam int OP_W = 4;

  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*OP_W-1:0] req_op;
  logic [2*XLEN-1:0] req_a;
  logic [2*XLEN-1:0] req_b;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [2*XLEN-1:0] rsp_data;
  logic [1:0]        rsp_err;
  logic [OP_W-1:0]   alu_ctrl;
  logic [XLEN-1:0]   alu_a;
  logic [XLEN-1:0]   alu_b;
  logic [XLEN-1:0]   alu_result;

  int checks = 0;
  int errors = 0;

  // Scoreboard: {err, data} expected in each response buffer.
  logic [XLEN:0] q0[$];
  logic [XLEN:0] q1[$];

  alu_share_arb #(.XLEN(XLEN), .OP_W(OP_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .alu_ctrl_o  (alu_ctrl),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_result_i(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU; undefined codes give a poison value.
  function automatic logic [XLEN-1:0] alu_model(input logic [OP_W-1:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a & b;
      4'd2:    return a | b;
      4'd3:    return a ^ b;
      4'd4:    return a << b[4:0];
      4'd5:    return a >> b[4:0];
      4'd6:    return XLEN'($signed(a) >>> b[4:0]);
      4'd7:    return a - b;
      4'd8:    return (a < b) ? 32'd1 : 32'd0;
      4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = alu_model(alu_ctrl, alu_a, alu_b);

  function automatic logic [XLEN:0] expect_rsp(input logic [OP_W-1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    if (op > 4'd9) return {1'b1, a + b};
    return {1'b0, alu_model(op, a, b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_buffers(input string tag);
    chk({tag, ".vld0"}, 64'(rsp_valid[0]), 64'(q0.size() != 0));
    chk({tag, ".vld1"}, 64'(rsp_valid[1]), 64'(q1.size() != 0));
    if (q0.size() != 0) begin
      chk({tag, ".data0"}, 64'(rsp_data[0 +: XLEN]), 64'(q0[0][XLEN-1:0]));
      chk({tag, ".err0"},  64'(rsp_err[0]),          64'(q0[0][XLEN]));
    end
    if (q1.size() != 0) begin
      chk({tag, ".data1"}, 64'(rsp_data[XLEN +: XLEN]), 64'(q1[0][XLEN-1:0]));
      chk({tag, ".err1"},  64'(rsp_err[1]),             64'(q1[0][XLEN]));
    end
  endtask

  // One clock cycle: drive, check grant/ALU drive mid-cycle, update the
  // scoreboard, then check the buffers just after the edge.
  task automatic step(input string tag, input logic [1:0] v,
                      input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                      input logic [1:0] rr, input logic [1:0] exp_g);
    logic [3:0]  eop;
    logic [31:0] ea, eb;
    req_valid = v;
    req_op    = {op1, op0};
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    rsp_ready = rr;
    @(negedge clk);
    chk({tag, ".ready"}, 64'(req_ready), 64'(exp_g));
    eop = 4'd0; ea = '0; eb = '0;
    if (exp_g == 2'b01) begin eop = op0; ea = a0; eb = b0; end
    if (exp_g == 2'b10) begin eop = op1; ea = a1; eb = b1; end
    chk({tag, ".ctrl"}, 64'(alu_ctrl), 64'((eop > 4'd9) ? 4'd0 : eop));
    chk({tag, ".alu_a"}, 64'(alu_a), 64'(ea));
    chk({tag, ".alu_b"}, 64'(alu_b), 64'(eb));
    if (q0.size() != 0 && rr[0]) void'(q0.pop_front());
    if (q1.size() != 0 && rr[1]) void'(q1.pop_front());
    if (exp_g[0]) q0.push_back(expect_rsp(op0, a0, b0));
    if (exp_g[1]) q1.push_back(expect_rsp(op1, a1, b1));
    @(posedge clk);
    #1;
    check_buffers(tag);
  endtask

  // Reset for one edge while both requesters present work that must be dropped.
  task automatic do_reset(input string tag);
    rst       = 1'b1;
    req_valid = 2'b11;
    req_op    = {4'd0, 4'd0};
    req_a     = {32'd11, 32'd22};
    req_b     = {32'd1, 32'd2};
    rsp_ready = 2'b00;
    @(negedge clk);
    chk({tag, ".ready_in_rst"}, 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 2'b00;
    q0.delete();
    q1.delete();
    chk({tag, ".vld"},  64'(rsp_valid), 64'd0);
    chk({tag, ".data"}, 64'(rsp_data),  64'd0);
    chk({tag, ".err"},  64'(rsp_err),   64'd0);
  endtask

  localparam logic [3:0] ADD = 4'd0, XOR = 4'd3, SLL = 4'd4, SRA = 4'd6;
  localparam logic [3:0] SUB = 4'd7, SLTU = 4'd8, SLT = 4'd9;

  initial begin
    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst0");
    @(negedge clk);
    chk("idle.ready", 64'(req_ready), 64'd0);
    chk("idle.ctrl",  64'(alu_ctrl),  64'd0);
    chk("idle.a",     64'(alu_a),     64'd0);
    chk("idle.b",     64'(alu_b),     64'd0);
    @(posedge clk);
    #1;

    // Single request on requester 0.
    step("single", 2'b01, SUB, 32'd10, 32'd3, ADD, 0, 0, 2'b11, 2'b01);
    step("single_idle", 2'b00, ADD, 0, 0, ADD, 0, 0, 2'b11, 2'b00);

    // Contention from reset: strict alternation starting with requester 0.
    do_reset("rst1");
    for (int i = 0; i < 4; i++)
      step("contend", 2'b11, ADD, 32'd1, 32'd2, XOR, 32'd5, 32'd3, 2'b11,
           (i % 2 == 0) ? 2'b01 : 2'b10);
    step("contend_drain", 2'b00, ADD, 0, 0, ADD, 0, 0, 2'b11, 2'b00);

    // Backpressure on requester 0 while requester 1 streams.
    do_reset("rst2");
    step("bp_fill", 2'b01, ADD, 32'd100, 32'd23, ADD, 0, 0, 2'b00, 2'b01);
    step("bp1", 2'b11, ADD, 32'd7, 32'd7, SLL, 32'd1, 32'd4, 2'b10, 2'b10);
    step("bp2", 2'b11, ADD, 32'd7, 32'd7, SRA, 32'h8000_0000, 32'd4, 2'b10, 2'b10);
    step("bp3", 2'b11, ADD, 32'd7, 32'd7, SLTU, 32'd3, 32'hFFFF_FFFF, 2'b10, 2'b10);
    step("bp_release", 2'b11, ADD, 32'd7, 32'd7, ADD, 32'd1, 32'd1, 2'b11, 2'b01);
    step("bp_drain", 2'b00, ADD, 0, 0, ADD, 0, 0, 2'b11, 2'b00);

    // Drain-and-refill with no bubble.
    do_reset("rst3");
    for (int i = 0; i < 4; i++)
      step("refill", 2'b01, SLT, 32'hFFFF_FFFF, 32'd1, ADD, 0, 0, 2'b01, 2'b01);
    step("refill_end", 2'b00, ADD, 0, 0, ADD, 0, 0, 2'b01, 2'b00);

    // Illegal op code on requester 1.
    step("illegal", 2'b10, ADD, 0, 0, 4'hF, 32'd4, 32'd5, 2'b10, 2'b10);
    step("illegal_end", 2'b00, ADD, 0, 0, ADD, 0, 0, 2'b10, 2'b00);

    // Reset with both buffers full, then first tie goes to requester 0.
    do_reset("rst4");
    step("mf_fill0", 2'b11, ADD, 32'd2, 32'd2, SUB, 32'd9, 32'd4, 2'b00, 2'b01);
    step("mf_fill1", 2'b11, ADD, 32'd2, 32'd2, SUB, 32'd9, 32'd4, 2'b00, 2'b10);
    do_reset("rst_mid");
    step("post_rst_tie", 2'b11, ADD, 32'd6, 32'd6, SUB, 32'd9, 32'd4, 2'b11, 2'b01);
    step("post_rst_tie2", 2'b11, ADD, 32'd6, 32'd6, SUB, 32'd9, 32'd4, 2'b11, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
